// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared pipeline constants, fetch action encoding and jump-target helper
package if_stage_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {
      ACT_SEQ,
      ACT_STALL,
      ACT_BRANCH,
      ACT_JUMP
   } fetch_act_e;

   // {pc[31:28], instr[25:0], 2'b00}, written with whole-word masks
   function automatic logic [31:0] jtarget(input logic [31:0] pc, input logic [31:0] instr);
      return (pc & 32'hF000_0000) | ((instr << 2) & 32'h0FFF_FFFC);
   endfunction

endpackage

// File: rtl/imem_rom.sv
// rtl/imem_rom.sv - word-addressed instruction array, synchronous write, combinational read
module imem_rom #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read sees the pre-edge contents, giving read-before-write
   assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, redirect/stall select, one-shot jump guard
module if_stage #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          br_taken,
   input  logic [31:0]                   br_target,
   input  logic                          jump,
   input  logic [31:0]                   ID_instruction,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   output logic [31:0]                   IF_instruction,
   output logic [31:0]                   IF_pc_plus4,
   output logic [31:0]                   pc
);

   import if_stage_pkg::*;

   localparam int          AW      = $clog2(IMEM_DEPTH);
   localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

   fetch_act_e    act;
   logic [31:0]   target;
   logic          jmp_done;
   logic [AW-1:0] raddr;
   logic [31:0]   rdata;
   logic [31:0]   fetched;
   logic          unused_bits;

   always_comb begin
      act    = ACT_SEQ;
      target = pc;
      if (br_taken) begin
         act    = ACT_BRANCH;
         target = {br_target[31:2], 2'b00};
      end else if (jump && !jmp_done) begin
         act    = ACT_JUMP;
         target = jtarget(pc, ID_instruction);
      end else if (stall) begin
         act = ACT_STALL;
      end
   end

   assign raddr       = target[AW+1:2];
   assign fetched     = (target[31:2] < DEPTH_W) ? rdata : NOP_INSTR;
   assign unused_bits = ^br_target[1:0];

   imem_rom #(
      .DEPTH (IMEM_DEPTH),
      .AW    (AW)
   ) u_imem (
      .clk   (clk),
      .we    (imem_we),
      .waddr (imem_waddr),
      .wdata (imem_wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc             <= RESET_PC;
         IF_instruction <= NOP_INSTR;
         IF_pc_plus4    <= 32'h0;
         jmp_done       <= 1'b0;
      end else begin
         // Guard re-arms only once decode drops jump; branches leave it alone
         if (!jump) begin
            jmp_done <= 1'b0;
         end else if (act == ACT_JUMP) begin
            jmp_done <= 1'b1;
         end
         if (act != ACT_STALL) begin
            IF_instruction <= fetched;
            IF_pc_plus4    <= target + 32'd4;
            pc             <= target + 32'd4;
         end
      end
   end

endmodule
